// File: rtl/dice_cgra_cfg_loader_if.sv
// Config word stream between the fetch path (master) and the CGRA config loader (slave).
interface dice_cgra_cfg_loader_if #(
  parameter int WORD_W = 32
);
  logic              cfg_word_valid;
  logic              cfg_word_ready;
  logic [WORD_W-1:0] cfg_word_data;

  modport master (
    output cfg_word_valid,
    output cfg_word_data,
    input  cfg_word_ready
  );

  modport slave (
    input  cfg_word_valid,
    input  cfg_word_data,
    output cfg_word_ready
  );
endinterface

// File: rtl/dice_cgra_cfg_loader.sv
// Streams a CGRA bitstream into a shadow register and commits it atomically to cgra_cfg
// once the array reports idle, so a running kernel never sees a partial configuration.
module dice_cgra_cfg_loader #(
  parameter int NUM_TILES  = 16,
  parameter int TILE_CFG_W = 156,
  parameter int WORD_W     = 32,
  localparam int CFG_W     = NUM_TILES * TILE_CFG_W,
  localparam int NUM_WORDS = (CFG_W + WORD_W - 1) / WORD_W,
  localparam int CNT_W     = $clog2(NUM_WORDS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_start,
  input  logic                         abort,
  dice_cgra_cfg_loader_if.slave        cfg_word,
  input  logic                         cgra_busy,
  output logic [CFG_W-1:0]             cgra_cfg,
  output logic                         cfg_valid,
  output logic                         load_done,
  output logic                         loader_busy,
  output logic [CNT_W-1:0]             word_cnt
);

  localparam int SHADOW_W = NUM_WORDS * WORD_W;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LOAD      = 2'd1;
  localparam logic [1:0] S_WAIT_IDLE = 2'd2;

  logic [1:0]          state;
  logic [SHADOW_W-1:0] shadow;
  logic                word_ready;
  logic                word_take;

  assign word_ready              = (state == S_LOAD) && !abort;
  assign cfg_word.cfg_word_ready = word_ready;
  assign word_take               = cfg_word.cfg_word_valid && word_ready;
  assign loader_busy             = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      word_cnt  <= '0;
      shadow    <= '0;
      cgra_cfg  <= '0;
      cfg_valid <= 1'b0;
      load_done <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_start && !abort) begin
            state    <= S_LOAD;
            word_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (word_take) begin
            // Shadow is padded to whole words; bits past CFG_W are simply never committed.
            for (int unsigned k = 0; k < NUM_WORDS; k++) begin
              if (word_cnt == CNT_W'(k))
                shadow[k*WORD_W +: WORD_W] <= cfg_word.cfg_word_data;
            end
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == CNT_W'(NUM_WORDS - 1))
              state <= S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (!cgra_busy) begin
            cgra_cfg  <= shadow[CFG_W-1:0];
            cfg_valid <= 1'b1;
            load_done <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dice_cgra_cfg_loader.sv
// Directed bench for dice_cgra_cfg_loader at default parameters (78 words of 32 bits).
module tb_dice_cgra_cfg_loader;
  localparam int CFG_W     = 2496;
  localparam int NUM_WORDS = 78;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load_start = 1'b0;
  logic             abort = 1'b0;
  logic             cgra_busy = 1'b0;
  logic [CFG_W-1:0] cgra_cfg;
  logic             cfg_valid;
  logic             load_done;
  logic             loader_busy;
  logic [6:0]       word_cnt;

  int n_cmp = 0;
  int n_err = 0;

  dice_cgra_cfg_loader_if #(.WORD_W(32)) wif ();

  dice_cgra_cfg_loader #(
    .NUM_TILES (16),
    .TILE_CFG_W(156),
    .WORD_W    (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .abort      (abort),
    .cfg_word   (wif),
    .cgra_busy  (cgra_busy),
    .cgra_cfg   (cgra_cfg),
    .cfg_valid  (cfg_valid),
    .load_done  (load_done),
    .loader_busy(loader_busy),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cfg(input string tag, input logic [CFG_W-1:0] exp);
    n_cmp++;
    assert (cgra_cfg === exp) else begin
      n_err++;
      $error("FAIL %s: observed low %h high %h, expected low %h high %h, %0d bits differ",
             tag, cgra_cfg[31:0], cgra_cfg[CFG_W-1 -: 32], exp[31:0], exp[CFG_W-1 -: 32],
             $countones(cgra_cfg ^ exp));
    end
  endtask

  function automatic logic [31:0] pat(input int mode, input int k);
    case (mode)
      0: return 32'(k + 1);
      1: return 32'h1000_0000 + 32'(k);
      2: return 32'hA5A5_A5A5;
      3: return 32'h5A5A_5A5A;
      4: return 32'(k * 3);
      default: return ~32'(k);
    endcase
  endfunction

  function automatic logic [CFG_W-1:0] build(input int mode);
    logic [CFG_W-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_WORDS; k++) v[k*32 +: 32] = pat(mode, k);
    return v;
  endfunction

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  // Sends words first..last-1 of a pattern; optional idle cycle after each word.
  task automatic send_words(input int mode, input int first, input int last, input bit gaps);
    for (int k = first; k < last; k++) begin
      wif.cfg_word_valid = 1'b1;
      wif.cfg_word_data  = pat(mode, k);
      step();
      if (gaps && k != last - 1) begin
        wif.cfg_word_valid = 1'b0;
        step();
      end
    end
    wif.cfg_word_valid = 1'b0;
  endtask

  initial begin
    logic [CFG_W-1:0] exp_a;
    logic [CFG_W-1:0] exp_prev;
    wif.cfg_word_valid = 1'b0;
    wif.cfg_word_data  = '0;

    // Reset
    #2 rst = 1'b1;
    #1;
    chk("reset_cfg_valid", cfg_valid, 0);
    chk("reset_load_done", load_done, 0);
    chk("reset_busy", loader_busy, 0);
    chk("reset_word_cnt", word_cnt, 0);
    chk("reset_ready", wif.cfg_word_ready, 0);
    chk_cfg("reset_cfg", '0);
    step();
    rst = 1'b0;
    step();

    // 1. Basic load, data = k+1
    start_load();
    chk("t1_ready_after_start", wif.cfg_word_ready, 1);
    chk("t1_busy_after_start", loader_busy, 1);
    send_words(0, 0, NUM_WORDS, 1'b0);
    chk("t1_no_done_before_commit", load_done, 0);
    chk("t1_word_cnt_last", word_cnt, 78);
    chk_cfg("t1_cfg_before_commit", '0);
    step();
    chk("t1_load_done", load_done, 1);
    chk("t1_cfg_valid", cfg_valid, 1);
    chk("t1_word_cnt", word_cnt, 78);
    chk("t1_cfg_low", cgra_cfg[31:0], 1);
    chk("t1_cfg_high", cgra_cfg[2495:2464], 78);
    chk_cfg("t1_cfg_full", build(0));
    step();
    chk("t1_done_one_cycle", load_done, 0);
    chk("t1_idle", loader_busy, 0);

    // 2. Same load with valid toggling every cycle
    start_load();
    send_words(0, 0, NUM_WORDS, 1'b1);
    chk("t2_no_done_at_last_word", load_done, 0);
    step();
    chk("t2_load_done", load_done, 1);
    chk_cfg("t2_cfg_full", build(0));
    step();

    // 3. cgra_busy holds the commit off
    exp_prev = build(0);
    start_load();
    send_words(1, 0, NUM_WORDS - 1, 1'b0);
    cgra_busy = 1'b1;
    send_words(1, NUM_WORDS - 1, NUM_WORDS, 1'b0);
    for (int i = 0; i < 10; i++) step();
    chk("t3_busy_held", loader_busy, 1);
    chk("t3_no_done_held", load_done, 0);
    chk("t3_ready_low_wait", wif.cfg_word_ready, 0);
    chk_cfg("t3_cfg_unchanged", exp_prev);
    cgra_busy = 1'b0;
    step();
    chk("t3_load_done", load_done, 1);
    chk_cfg("t3_cfg_committed", build(1));
    step();
    chk("t3_done_one_cycle", load_done, 0);

    // 4. Load A all-A5, then abort load B after word 40
    exp_a = build(2);
    start_load();
    send_words(2, 0, NUM_WORDS, 1'b0);
    step();
    chk_cfg("t4_cfg_a", exp_a);
    step();
    start_load();
    send_words(3, 0, 41, 1'b0);
    abort = 1'b1;
    #1;
    chk("t4_ready_low_abort", wif.cfg_word_ready, 0);
    step();
    abort = 1'b0;
    chk("t4_idle_after_abort", loader_busy, 0);
    chk("t4_word_cnt", word_cnt, 41);
    chk("t4_no_done", load_done, 0);
    chk("t4_cfg_valid", cfg_valid, 1);
    chk_cfg("t4_cfg_still_a", exp_a);
    step();
    chk("t4_no_done_later", load_done, 0);
    // Abort beats commit in WAIT_IDLE
    start_load();
    cgra_busy = 1'b1;
    send_words(3, 0, NUM_WORDS, 1'b0);
    cgra_busy = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_wait_abort_no_done", load_done, 0);
    chk("t4_wait_abort_idle", loader_busy, 0);
    chk_cfg("t4_wait_abort_cfg", exp_a);

    // 5. load_start mid-load ignored; abort beats word and load_start
    start_load();
    send_words(4, 0, 20, 1'b0);
    load_start = 1'b1;
    send_words(4, 20, 21, 1'b0);
    load_start = 1'b0;
    chk("t5_word_cnt_after_restart", word_cnt, 21);
    send_words(4, 21, NUM_WORDS, 1'b0);
    chk("t5_word_cnt", word_cnt, 78);
    step();
    chk("t5_load_done", load_done, 1);
    chk_cfg("t5_cfg", build(4));
    step();
    start_load();
    send_words(5, 0, 5, 1'b0);
    wif.cfg_word_valid = 1'b1;
    wif.cfg_word_data  = 32'hDEAD_BEEF;
    abort = 1'b1;
    #1;
    chk("t5_ready_abort_word", wif.cfg_word_ready, 0);
    step();
    abort = 1'b0;
    wif.cfg_word_valid = 1'b0;
    chk("t5_word_not_taken", word_cnt, 5);
    chk("t5_abort_idle", loader_busy, 0);
    load_start = 1'b1;
    abort = 1'b1;
    step();
    load_start = 1'b0;
    abort = 1'b0;
    chk("t5_abort_beats_start", loader_busy, 0);
    chk_cfg("t5_cfg_kept", build(4));

    // 6. Reset mid-load, then fresh load
    start_load();
    send_words(3, 0, 50, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", loader_busy, 0);
    chk("t6_rst_cfg_valid", cfg_valid, 0);
    chk("t6_rst_word_cnt", word_cnt, 0);
    chk("t6_rst_ready", wif.cfg_word_ready, 0);
    chk("t6_rst_done", load_done, 0);
    chk_cfg("t6_rst_cfg", '0);
    step();
    rst = 1'b0;
    step();
    start_load();
    send_words(5, 0, NUM_WORDS, 1'b0);
    step();
    chk("t6_load_done", load_done, 1);
    chk("t6_cfg_valid", cfg_valid, 1);
    chk_cfg("t6_cfg", build(5));
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
